generic_pipelined_subtractor: RTL and testbench

- Pipelined unsigned subtractor: Q = A - B - BI, with borrow-out, for wide counters and timestamp differences in the ATRI datapath.
- Counterpart of the pipelined carry-chain adder: the borrow chain is split into STAGES equal chunks, with one register per chunk boundary.
- Runs at full throughput (one operation per enabled cycle), with input operand skew and output deskew.

---
 rtl/generic_pipelined_subtractor.sv | 172 +++++++++++++++++
 tb/tb_generic_pipelined_subtractor.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/generic_pipelined_subtractor.sv
// generic_pipelined_subtractor
//
// Pipelined unsigned subtractor: {BO, Q} = A - B - BI.
// The borrow chain is cut into STAGES chunks of CW = WIDTH/STAGES bits, with one register per
// chunk boundary. Operand chunk k is skewed by k stages so that it meets the registered borrow
// of chunk k-1 for the same operation. Result chunk k is then deskewed by STAGES-1-k stages so
// that all chunks of Q leave together.
// Latency is STAGES enabled edges. Throughput is one operation per enabled cycle.
//
// Parameters:
//   WIDTH   operand/result width (must be a multiple of STAGES)
//   STAGES  pipeline depth / number of chunks
//
// Ports:
//   clk_i    system clock, rising edge
//   rst_i    asynchronous active-high reset; clears every register
//   ce_i     clock enable; the whole pipeline holds when low
//   valid_i  A/B/BI carry a real operation
//   A, B     minuend, subtrahend
//   BI       borrow-in
//   Q        difference mod 2^WIDTH
//   BO       borrow-out (A < B + BI, unsigned)
//   valid_o  Q/BO belong to an accepted operation
//   OV       signed overflow, only when GENERIC_PIPELINED_SUBTRACTOR_OVERFLOW_EN is defined
//
// Optional feature macro: GENERIC_PIPELINED_SUBTRACTOR_OVERFLOW_EN

module generic_pipelined_subtractor #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BI,
  output logic [WIDTH-1:0] Q,
  output logic             BO,
  output logic             valid_o
`ifdef GENERIC_PIPELINED_SUBTRACTOR_OVERFLOW_EN
  ,
  output logic             OV
`endif
);

  localparam int unsigned CW = WIDTH / STAGES;

  if ((WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("WIDTH must be a multiple of STAGES");
  end

  // Skewed operand chunks as seen by each chunk subtractor
  logic [STAGES-1:0][CW-1:0] a_sk;
  logic [STAGES-1:0][CW-1:0] b_sk;
  // Registered borrow-out of each chunk
  logic [STAGES-1:0]         bo_w;
  // valid_i shift register, in lockstep with the data
  logic [STAGES-1:0]         vld_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_chunk
    localparam int unsigned Dsk = STAGES - 1 - k;

    logic          bin;
    logic [CW:0]   diff;
    logic [CW-1:0] d_q;
    logic          b_q;

    if (k == 0) begin : g_bin_ext
      assign bin = BI;
    end else begin : g_bin_chain
      assign bin = bo_w[k-1];
    end

    // Operand skew: k register stages ahead of the subtractor
    if (k == 0) begin : g_noskew
      assign a_sk[k] = A[k*CW +: CW];
      assign b_sk[k] = B[k*CW +: CW];
    end else begin : g_skew
      logic [k-1:0][CW-1:0] a_line_q;
      logic [k-1:0][CW-1:0] b_line_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          a_line_q <= '0;
          b_line_q <= '0;
        end else if (ce_i) begin
          a_line_q[0] <= A[k*CW +: CW];
          b_line_q[0] <= B[k*CW +: CW];
          for (int i = 1; i < k; i++) begin
            a_line_q[i] <= a_line_q[i-1];
            b_line_q[i] <= b_line_q[i-1];
          end
        end
      end

      assign a_sk[k] = a_line_q[k-1];
      assign b_sk[k] = b_line_q[k-1];
    end

    // CW+1 bit subtract: the extra top bit is the chunk borrow-out
    assign diff = {1'b0, a_sk[k]} - {1'b0, b_sk[k]} - {{CW{1'b0}}, bin};

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        d_q <= '0;
        b_q <= 1'b0;
      end else if (ce_i) begin
        d_q <= diff[CW-1:0];
        b_q <= diff[CW];
      end
    end

    assign bo_w[k] = b_q;

    // Output deskew: STAGES-1-k further stages
    if (Dsk == 0) begin : g_nodeskew
      assign Q[k*CW +: CW] = d_q;
    end else begin : g_deskew
      logic [Dsk-1:0][CW-1:0] q_line_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          q_line_q <= '0;
        end else if (ce_i) begin
          q_line_q[0] <= d_q;
          for (int i = 1; i < int'(Dsk); i++) begin
            q_line_q[i] <= q_line_q[i-1];
          end
        end
      end

      assign Q[k*CW +: CW] = q_line_q[Dsk-1];
    end

`ifdef GENERIC_PIPELINED_SUBTRACTOR_OVERFLOW_EN
    // Top chunk has no deskew, so a register here lines up with Q/BO
    if (k == STAGES - 1) begin : g_ov
      logic ov_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          ov_q <= 1'b0;
        end else if (ce_i) begin
          ov_q <= (a_sk[k][CW-1] != b_sk[k][CW-1]) && (diff[CW-1] != a_sk[k][CW-1]);
        end
      end

      assign OV = ov_q;
    end
`else
    // No overflow flag in this build
`endif
  end

  assign BO = bo_w[STAGES-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
    end else if (ce_i) begin
      vld_q[0] <= valid_i;
      for (int i = 1; i < int'(STAGES); i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign valid_o = vld_q[STAGES-1];

endmodule

// File: tb/tb_generic_pipelined_subtractor.sv
// Self-checking bench for generic_pipelined_subtractor (WIDTH=32, STAGES=4).
// Expected results come from plain wide arithmetic, timed by counting enabled edges.

module tb_generic_pipelined_subtractor;

  localparam int unsigned W = 32;
  localparam int unsigned S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         ce;
  logic         vin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bi;
  logic [W-1:0] q;
  logic         bo;
  logic         vout;
`ifdef GENERIC_PIPELINED_SUBTRACTOR_OVERFLOW_EN
  logic         ov;
`endif

  always #5 clk = ~clk;

  generic_pipelined_subtractor #(
    .WIDTH  (W),
    .STAGES (S)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .ce_i    (ce),
    .valid_i (vin),
    .A       (a),
    .B       (b),
    .BI      (bi),
    .Q       (q),
    .BO      (bo),
    .valid_o (vout)
`ifdef GENERIC_PIPELINED_SUBTRACTOR_OVERFLOW_EN
    ,
    .OV      (ov)
`endif
  );

  typedef struct {
    logic [W-1:0] q;
    logic         bo;
    logic         ov;
    int           due;
  } exp_t;

  exp_t exp_q[$];
  int   en_cnt;
  int   n_total;
  int   n_bad;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Compare DUT outputs against the oldest outstanding operation
  task automatic compare();
    exp_t e;
    logic ev;
    while (exp_q.size() > 0 && exp_q[0].due < en_cnt) void'(exp_q.pop_front());
    ev = (exp_q.size() > 0) && (exp_q[0].due == en_cnt);
    check_eq("valid_o", 64'(vout), 64'(ev));
    if (ev) begin
      e = exp_q[0];
      check_eq("Q", 64'(q), 64'(e.q));
      check_eq("BO", 64'(bo), 64'(e.bo));
`ifdef GENERIC_PIPELINED_SUBTRACTOR_OVERFLOW_EN
      check_eq("OV", 64'(ov), 64'(e.ov));
`endif
    end
  endtask

  // One clock: record what the DUT samples, then check 1 ns after the edge
  task automatic cycle();
    logic [W:0] r;
    exp_t       e;
    @(posedge clk);
    if (!rst && ce) begin
      en_cnt++;
      if (vin) begin
        r     = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
        e.q   = r[W-1:0];
        e.bo  = r[W];
        e.ov  = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        e.due = en_cnt + S - 1;
        exp_q.push_back(e);
      end
    end
    #1;
    if (!rst) compare();
  endtask

  task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in);
    a   = av;
    b   = bv;
    bi  = bv_in;
    vin = 1'b1;
    ce  = 1'b1;
  endtask

  logic [W-1:0] bb_a [4] = '{32'd5, 32'd3, 32'h12345678, 32'hFFFFFFFF};
  logic [W-1:0] bb_b [4] = '{32'd3, 32'd5, 32'h12345678, 32'h00000000};
  logic         bb_i [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [W-1:0] bb_q [4] = '{32'h2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic         bb_o [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    int ops;
    n_total = 0;
    n_bad   = 0;
    en_cnt  = 0;
    rst = 1'b1;
    ce  = 1'b0;
    vin = 1'b0;
    a   = '0;
    b   = '0;
    bi  = 1'b0;

    // Reset state
    #3;
    check_eq("rst_Q", 64'(q), 64'h0);
    check_eq("rst_BO", 64'(bo), 64'h0);
    check_eq("rst_valid", 64'(vout), 64'h0);
    cycle();
    cycle();
    rst = 1'b0;

    // Full borrow ripple
    drive(32'h0, 32'h1, 1'b0);
    cycle();
    vin = 1'b0;
    repeat (3) cycle();
    check_eq("ripple_Q", 64'(q), 64'hFFFFFFFF);
    check_eq("ripple_BO", 64'(bo), 64'h1);
    check_eq("ripple_valid", 64'(vout), 64'h1);
    cycle();
    check_eq("ripple_once", 64'(vout), 64'h0);

    // Back-to-back stream
    for (int i = 0; i < 4; i++) begin
      drive(bb_a[i], bb_b[i], bb_i[i]);
      cycle();
    end
    vin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cycle();
      check_eq("b2b_Q", 64'(q), 64'(bb_q[i]));
      check_eq("b2b_BO", 64'(bo), 64'(bb_o[i]));
      check_eq("b2b_valid", 64'(vout), 64'h1);
    end
    cycle();

    // Stall mid-flight
    drive(32'h100, 32'h1, 1'b0);
    cycle();
    vin = 1'b0;
    cycle();
    ce = 1'b0;
    repeat (3) cycle();
    ce = 1'b1;
    cycle();
    check_eq("stall_early", 64'(vout), 64'h0);
    cycle();
    check_eq("stall_Q", 64'(q), 64'hFF);
    check_eq("stall_BO", 64'(bo), 64'h0);
    check_eq("stall_valid", 64'(vout), 64'h1);
    ce = 1'b0;
    repeat (2) cycle();
    check_eq("stall_hold", 64'(vout), 64'h1);
    ce = 1'b1;
    cycle();
    check_eq("stall_norepeat", 64'(vout), 64'h0);

    // Reset mid-flight
    for (int i = 0; i < 3; i++) begin
      drive($urandom, $urandom, 1'($urandom_range(0, 1)));
      cycle();
    end
    vin = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_Q", 64'(q), 64'h0);
    check_eq("midrst_BO", 64'(bo), 64'h0);
    check_eq("midrst_valid", 64'(vout), 64'h0);
    exp_q.delete();
    en_cnt = 0;
    repeat (2) cycle();
    rst = 1'b0;
    repeat (3) cycle();
    drive(32'd7, 32'd2, 1'b0);
    cycle();
    vin = 1'b0;
    repeat (3) cycle();
    check_eq("postrst_Q", 64'(q), 64'd5);
    check_eq("postrst_valid", 64'(vout), 64'h1);
    cycle();

`ifdef GENERIC_PIPELINED_SUBTRACTOR_OVERFLOW_EN
    drive(32'h80000000, 32'h1, 1'b0);
    cycle();
    drive(32'h5, 32'h3, 1'b0);
    cycle();
    vin = 1'b0;
    repeat (2) cycle();
    check_eq("ov1_Q", 64'(q), 64'h7FFFFFFF);
    check_eq("ov1_OV", 64'(ov), 64'h1);
    check_eq("ov1_BO", 64'(bo), 64'h0);
    cycle();
    check_eq("ov0_OV", 64'(ov), 64'h0);
    cycle();
`endif

    // Randomized stream with random enable/valid and boundary-biased operands
    ops = 0;
    for (int c = 0; c < 40000 && ops < 10000; c++) begin
      ce  = ($urandom_range(0, 3) != 0);
      vin = ($urandom_range(0, 4) != 0);
      bi  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       begin a = $urandom; b = a; end
        1:       begin a = '0; b = $urandom_range(0, 2); end
        2:       begin a = 32'hFFFFFFFF; b = $urandom; end
        3:       begin a = $urandom_range(0, 255); b = $urandom_range(0, 255); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      if (ce && vin) ops++;
      cycle();
    end
    ce  = 1'b1;
    vin = 1'b0;
    repeat (S + 1) cycle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
